instr_fetch: RTL
================

# instr_fetch

Program-counter and instruction-store stage feeding the 4-bit multicycle core. It holds a small writable instruction memory that is loaded while the core is idle. On each fetch request it presents the instruction at the current PC on `next`, then advances the PC. It stops or wraps at the end of the loaded program. It sits directly upstream of the core's IF stage and drives the core's `next` input.

## Interface
- `WIDTH`, 4: instruction width in bits.
- `DEPTH`, 8: instruction memory entries.
- `AW`, 3: address width, log2(DEPTH).
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `prog_we` input 1: write strobe for program load; honoured only in IDLE.
- `prog_addr` input AW: write address.
- `prog_data` input WIDTH: instruction to write.
- `run` input 1: start execution from PC 0; honoured only in IDLE or DONE.
- `loop` input 1: 1 = wrap the PC to 0 after the last instruction; 0 = stop.
- `fetch_req` input 1: the core requests the next instruction; issued one cycle before the core's IF edge.
- `next` output WIDTH: fetched instruction, held until the next fetch.
- `next_valid` output 1: one-cycle pulse when `next` is updated.
- `pc` output AW: address of the next instruction to fetch.
- `done` output 1: high while in DONE.

## Operation
- States: IDLE, RUN, DONE. Encoding is 2 bits, from the shared package.
- Program length register `len` (AW+1 bits).
  - In IDLE, each accepted `prog_we` writes `mem[prog_addr]`.
  - Each accepted write sets `len` to max(`len`, `prog_addr`+1).
- IDLE:
  - `prog_we` writes memory.
  - `run` with `len`≠0 → RUN, `pc`←0.
  - `run` with `len`=0 → DONE.
  - `fetch_req` is ignored.
- RUN:
  - `fetch_req` → `next`←`mem[pc]`, `next_valid`←1 for one cycle.
  - If `pc`+1 = `len`: with `loop`=1, `pc`←0 and stay in RUN; with `loop`=0, go to DONE with `pc` held at `len`-1.
  - Otherwise `pc`←`pc`+1.
  - `prog_we` and `run` are ignored.
- DONE:
  - `fetch_req` is ignored; `next_valid` stays 0 and `next` holds.
  - `run` → RUN with `pc`←0 (re-run without reload).
  - There is no return to IDLE except through `rst`; a program reload requires reset.
- Simultaneous `prog_we` and `run` in IDLE: the write lands first; `len` and the start decision use the post-write length, and the state becomes RUN.
- Arithmetic: `pc` increments modulo DEPTH. `len` saturates at DEPTH.
- `prog_addr` ≥ DEPTH cannot occur (AW bits).

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, `pc`=0, `len`=0, `next`=0, `next_valid`=0, `done`=0.
  - All memory entries are cleared to 0.
- Fetch latency is 1 cycle. A `fetch_req` sampled at edge N produces `next`/`next_valid` valid after edge N. The core samples `next` at edge N+1.
- `next` is registered and changes only on accepted fetches or reset.
- `done` is registered and rises on the edge after the final fetch when `loop`=0.
- Back-to-back `fetch_req` (every cycle) is legal; each returns consecutive instructions.
- Reset mid-RUN aborts immediately:
  - The loaded program is lost.
  - `next_valid` drops the same instant.

## Structure
- Shared package contains:
  - State encodings `S_IDLE`=2'b00, `S_RUN`=2'b01, `S_DONE`=2'b10.
  - Default `WIDTH`/`DEPTH` constants, which the core also uses.
- One sub-module, `instr_mem`: DEPTH×WIDTH register array with a synchronous write port, an asynchronous read port and an asynchronous clear on `rst`.
- `instr_fetch` owns the FSM, `pc`, `len` and the output registers.

## Test plan
- Reset mid-operation:
  - Stimulus: assert `rst` while in RUN with `pc`=2.
  - Required response: `pc`=0, `next`=0, `next_valid`=0 and state IDLE immediately; a subsequent `run` goes straight to DONE because `len`=0.
- Load and single run:
  - Stimulus: write 4'b0001@0, 4'b1010@1, 4'b0110@2; `loop`=0; pulse `run`; issue 3 `fetch_req` pulses.
  - Required response: `next` = 1, A, 6, each with one `next_valid` pulse; `done`=1 after the third; a 4th `fetch_req` gives no pulse and `next` stays 6.
- Loop wrap:
  - Stimulus: same program as above, `loop`=1, 5 consecutive-cycle `fetch_req`.
  - Required response: `next` sequence 1, A, 6, 1, A; `pc` ends at 2; `done`=0.
- Empty program:
  - Stimulus: pulse `run` immediately after reset.
  - Required response: DONE on the next edge; `fetch_req` yields no `next_valid`.
- Ignored inputs in RUN:
  - Stimulus: `prog_we` to address 0 with 4'hF, plus `run`, during RUN.
  - Required response: memory is unchanged, and `pc` is not reset.
- Simultaneous write and run:
  - Stimulus: in IDLE after reset, assert `prog_we` (addr 0, data 4'h3) and `run` in the same cycle.
  - Required response: state RUN, `len`=1; the first fetch returns 3, then DONE.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage and the 4-bit multicycle core:
// FSM state encodings and the default instruction geometry.
package instr_fetch_pkg;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/instr_mem.sv
// Small instruction store: synchronous write, asynchronous read, and an
// asynchronous clear so that a reset discards the loaded program.
module instr_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Program counter and fetch FSM: loads a program while idle, then hands one
// instruction per fetch request to the core, stopping or wrapping at the end.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int WIDTH = instr_fetch_pkg::WIDTH,
  parameter int DEPTH = instr_fetch_pkg::DEPTH,
  parameter int AW    = instr_fetch_pkg::AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [WIDTH-1:0] prog_data,
  input  logic             run,
  input  logic             loop,
  input  logic             fetch_req,
  output logic [WIDTH-1:0] next,
  output logic             next_valid,
  output logic [AW-1:0]    pc,
  output logic             done
);

  state_t           state, state_n;
  logic [AW-1:0]    pc_n;
  logic [AW:0]      len, len_n, len_written;
  logic [AW:0]      addr_plus1, pc_plus1;
  logic [WIDTH-1:0] next_n, rdata;
  logic             next_valid_n, mem_we;

  instr_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (rdata)
  );

  // prog_addr is only AW bits wide, so addr+1 never exceeds DEPTH and len
  // saturates there without an explicit clamp.
  assign addr_plus1  = {1'b0, prog_addr} + {{AW{1'b0}}, 1'b1};
  assign pc_plus1    = {1'b0, pc} + {{AW{1'b0}}, 1'b1};
  assign len_written = (prog_we && (addr_plus1 > len)) ? addr_plus1 : len;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    len_n        = len;
    next_n       = next;
    next_valid_n = 1'b0;
    mem_we       = 1'b0;
    case (state)
      S_IDLE: begin
        // A write in the same cycle as run counts toward the start decision.
        mem_we = prog_we;
        len_n  = len_written;
        if (run) begin
          if (len_written != '0) begin
            state_n = S_RUN;
            pc_n    = '0;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (fetch_req) begin
          next_n       = rdata;
          next_valid_n = 1'b1;
          if (pc_plus1 == len) begin
            if (loop) begin
              pc_n = '0;
            end else begin
              state_n = S_DONE;
            end
          end else begin
            pc_n = pc_plus1[AW-1:0];
          end
        end
      end
      S_DONE: begin
        // An empty program has nothing to re-run, so stay put.
        if (run && (len != '0)) begin
          state_n = S_RUN;
          pc_n    = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      len        <= '0;
      next       <= '0;
      next_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      len        <= len_n;
      next       <= next_n;
      next_valid <= next_valid_n;
      done       <= (state_n == S_DONE);
    end
  end

endmodule
